// File: rtl/reaction_display.sv
// reaction_display: double-dabble BCD conversion and multiplexed 4-digit seven-segment drive.
// Optional LEADING_ZERO_BLANK_EN unlights leading zero digits in number mode.
module reaction_display #(
  parameter int VALUE_W   = 14,
  parameter int REFRESH_W = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic [3:0]         an,
  output logic [6:0]         sseg
);
  localparam int CW = $clog2(VALUE_W + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]           state;
  logic [VALUE_W-1:0]   bin, clamped;
  logic [15:0]          bcd, adj, bcd_n, shown;
  logic [CW-1:0]        bits;
  logic [REFRESH_W-1:0] scan;
  logic [1:0]           idx;
  logic [3:0]           dig, an_n;
  logic [6:0]           code, pat, sseg_n;
  logic                 lz_lit, lit;
  assign busy    = state == SHIFT;
  assign clamped = (32'(value) > 32'd9999) ? VALUE_W'(9999) : value;
  for (genvar n = 0; n < 4; n++) begin : g_adj
    assign adj[4*n+:4] = (bcd[4*n+:4] >= 4'd5) ? bcd[4*n+:4] + 4'd3 : bcd[4*n+:4];
  end
  assign bcd_n = {adj[14:0], bin[VALUE_W-1]};
  assign idx   = scan[REFRESH_W-1:REFRESH_W-2];
  assign dig   = shown[4*idx+:4];
`ifdef LEADING_ZERO_BLANK_EN
  // Blanking looks only at committed digits, never at the in-flight shift register.
  assign lz_lit = (idx == 2'd3) ? |shown[15:12] :
                  (idx == 2'd2) ? |shown[15:8]  :
                  (idx == 2'd1) ? |shown[15:4]  : 1'b1;
`else
  assign lz_lit = 1'b1;
`endif
  always_comb begin
    code = 7'b1111111;
    case (dig)
      4'd0: code = 7'b1000000;
      4'd1: code = 7'b1111001;
      4'd2: code = 7'b0100100;
      4'd3: code = 7'b0110000;
      4'd4: code = 7'b0011001;
      4'd5: code = 7'b0010010;
      4'd6: code = 7'b0000010;
      4'd7: code = 7'b1111000;
      4'd8: code = 7'b0000000;
      4'd9: code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
  end
  always_comb begin
    lit    = (mode == 2'b11) ? 1'b1 : (mode == 2'b10) ? lz_lit : (mode == 2'b01) ? (idx < 2'd2) : 1'b0;
    pat    = (mode == 2'b11) ? 7'b0000000 : (mode == 2'b01) ? (idx[0] ? 7'b0001001 : 7'b1111001) : code;
    an_n   = lit ? ~(4'b0001 << idx) : 4'b1111;
    sseg_n = lit ? pat : 7'b1111111;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      bits  <= '0;
      shown <= '0;
      scan  <= '0;
      an    <= 4'b1111;
      sseg  <= 7'b1111111;
    end else begin
      scan <= scan + 1'b1;
      an   <= an_n;
      sseg <= sseg_n;
      // A new load always wins, restarting any conversion in flight.
      if (load) begin
        state <= SHIFT;
        bin   <= clamped;
        bcd   <= '0;
        bits  <= CW'(VALUE_W);
      end else if (state == SHIFT) begin
        bcd  <= bcd_n;
        bin  <= bin << 1;
        bits <= bits - 1'b1;
        if (bits == CW'(1)) begin
          state <= IDLE;
          shown <= bcd_n;
        end
      end
    end
  end
endmodule
